// File: rtl/ftm_buf_pkg.sv
// Shared constants, shape-word layout and FSM encoding for the feature-map buffer writer.
// Imported by ftm_wr_addr_gen and ftm_buffer_writer.
package ftm_buf_pkg;

    localparam int N_BUF_X_DEF    = 10;
    localparam int B_BUF_ADDR_DEF = 9;
    localparam int B_SHAPE_DEF    = 25;
    localparam int DATA_WIDTH_DEF = 64;

    localparam int SHP_W_LSB  = 0;
    localparam int SHP_W_BITS = 9;
    localparam int SHP_H_LSB  = 9;
    localparam int SHP_H_BITS = 9;
    localparam int SHP_C_LSB  = 18;
    localparam int SHP_C_BITS = 7;

    // Column depth (n_wrap_c*h) and whole-frame depth widths
    localparam int B_COL   = SHP_H_BITS + SHP_C_BITS;
    localparam int B_FRAME = B_COL + SHP_W_BITS;

    typedef struct packed {
        logic [SHP_C_BITS-1:0] c;
        logic [SHP_H_BITS-1:0] h;
        logic [SHP_W_BITS-1:0] w;
    } shape_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_WAIT_SPACE = 3'd2,
        ST_WRITE      = 3'd3,
        ST_COMMIT     = 3'd4
    } wr_state_t;

    function automatic logic shape_is_empty(input shape_t s);
        return (s.w == '0) || (s.h == '0) || (s.c == '0);
    endfunction

endpackage

// File: rtl/ftm_buffer_writer_if.sv
// Word-stream handshake into the buffer writer: master drives data, slave returns ready.
interface ftm_buffer_writer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/ftm_wr_addr_gen.sv
// Walks the frame in stream order (c, y, then x) and produces bank one-hot and bank address
// for the current word: addr = base_ptr + col_base + lin, wrapping at the bank depth.
module ftm_wr_addr_gen
    import ftm_buf_pkg::*;
#(
    parameter int N_BUF_X    = N_BUF_X_DEF,
    parameter int B_BUF_ADDR = B_BUF_ADDR_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [B_COL-1:0]      col_size,
    input  logic [SHP_W_BITS-1:0] w,
    input  logic [B_BUF_ADDR-1:0] base_ptr,
    output logic [N_BUF_X-1:0]    bank_onehot,
    output logic [B_BUF_ADDR-1:0] addr,
    output logic                  last
);

    localparam int XR_W = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;

    logic [B_COL-1:0]      lin_reg;
    logic [XR_W-1:0]       x_rem_reg;
    logic [SHP_W_BITS-1:0] x_reg;
    logic [B_BUF_ADDR-1:0] col_base_reg;
    logic                  col_end;

    assign col_end = (lin_reg == col_size - B_COL'(1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lin_reg      <= '0;
            x_rem_reg    <= '0;
            x_reg        <= '0;
            col_base_reg <= '0;
        end else if (advance) begin
            if (col_end) begin
                lin_reg <= '0;
                x_reg   <= x_reg + SHP_W_BITS'(1);
                // After the last bank the next column lands one column-depth further down
                if (x_rem_reg == XR_W'(N_BUF_X - 1)) begin
                    x_rem_reg    <= '0;
                    col_base_reg <= col_base_reg + col_size[B_BUF_ADDR-1:0];
                end else begin
                    x_rem_reg <= x_rem_reg + XR_W'(1);
                end
            end else begin
                lin_reg <= lin_reg + B_COL'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_BUF_X; gi++) begin : g_bank_sel
            assign bank_onehot[gi] = (x_rem_reg == XR_W'(gi));
        end
    endgenerate

    assign addr = base_ptr + col_base_reg + lin_reg[B_BUF_ADDR-1:0];
    assign last = col_end && (x_reg == w - SHP_W_BITS'(1));

endmodule

// File: rtl/ftm_buffer_writer.sv
// Write side of the banked feature-map ring buffer; the frame is committed by one wptr step.
// Optional build macro FTM_WR_LAST_CHECK_EN: checks s_last against the shape and flags err.
module ftm_buffer_writer
    import ftm_buf_pkg::*;
#(
    parameter int N_BUF_X    = N_BUF_X_DEF,
    parameter int B_BUF_ADDR = B_BUF_ADDR_DEF,
    parameter int B_SHAPE    = B_SHAPE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [B_SHAPE-1:0]             ftm_shape,
    output logic                           busy,
    output logic                           done,
    ftm_buffer_writer_if.slave             s,
    output logic [N_BUF_X-1:0]             wr_en,
    output logic [B_BUF_ADDR*N_BUF_X-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [B_BUF_ADDR-1:0]          rptr,
    output logic [B_BUF_ADDR-1:0]          wptr,
    output logic                           err
);

    localparam int B_SX = SHP_W_BITS + $clog2(N_BUF_X + 1);

    wr_state_t                      state_reg;
    shape_t                         shape_in;
    shape_t                         shape_reg;
    logic [B_COL-1:0]               col_size_reg;
    logic [B_FRAME-1:0]             frame_size_reg;
    logic [B_SX-1:0]                setup_x_reg;
    logic [B_SX-1:0]                setup_x_next;
    logic                           setup_first_reg;
    logic                           busy_reg;
    logic                           done_reg;
    logic                           s_ready_reg;
    logic [N_BUF_X-1:0]             wr_en_reg;
    logic [B_BUF_ADDR*N_BUF_X-1:0]  wr_addr_reg;
    logic [B_BUF_ADDR*N_BUF_X-1:0]  wr_addr_next;
    logic [DATA_WIDTH-1:0]          wr_data_reg;
    logic [B_BUF_ADDR-1:0]          wptr_reg;
    logic [B_BUF_ADDR-1:0]          free_slots;
    logic                           space_ok;
    logic                           xfer;
    logic                           gen_clear;
    logic                           gen_last;
    logic [N_BUF_X-1:0]             bank_onehot;
    logic [B_BUF_ADDR-1:0]          gen_addr;

    assign shape_in = shape_t'(ftm_shape);

    // One slot stays empty so that wptr == rptr always means "buffer empty"
    assign free_slots   = rptr - wptr_reg - B_BUF_ADDR'(1);
    assign space_ok     = (frame_size_reg <= B_FRAME'(free_slots));
    assign xfer         = s.s_valid && s_ready_reg;
    assign gen_clear    = (state_reg == ST_SETUP);
    assign setup_x_next = setup_x_reg + B_SX'(N_BUF_X);

    ftm_wr_addr_gen #(
        .N_BUF_X    (N_BUF_X),
        .B_BUF_ADDR (B_BUF_ADDR)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (gen_clear),
        .advance     (xfer),
        .col_size    (col_size_reg),
        .w           (shape_reg.w),
        .base_ptr    (wptr_reg),
        .bank_onehot (bank_onehot),
        .addr        (gen_addr),
        .last        (gen_last)
    );

    generate
        for (genvar gi = 0; gi < N_BUF_X; gi++) begin : g_lane_addr
            assign wr_addr_next[gi*B_BUF_ADDR +: B_BUF_ADDR] = bank_onehot[gi] ? gen_addr : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            shape_reg       <= '0;
            col_size_reg    <= '0;
            frame_size_reg  <= '0;
            setup_x_reg     <= '0;
            setup_first_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            s_ready_reg     <= 1'b0;
            wr_en_reg       <= '0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            wptr_reg        <= '0;
        end else begin
            done_reg    <= 1'b0;
            wr_en_reg   <= '0;
            wr_addr_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        shape_reg <= shape_in;
                        if (shape_is_empty(shape_in)) begin
                            done_reg <= 1'b1;
                        end else begin
                            busy_reg        <= 1'b1;
                            setup_first_reg <= 1'b1;
                            state_reg       <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (setup_first_reg) begin
                        setup_first_reg <= 1'b0;
                        col_size_reg    <= B_COL'(shape_reg.c) * B_COL'(shape_reg.h);
                        frame_size_reg  <= '0;
                        setup_x_reg     <= '0;
                    end else begin
                        // One column-depth per group of N_BUF_X columns, i.e. ceil(w/N_BUF_X) adds
                        frame_size_reg <= frame_size_reg + B_FRAME'(col_size_reg);
                        setup_x_reg    <= setup_x_next;
                        if (setup_x_next >= B_SX'(shape_reg.w)) begin
                            state_reg <= ST_WAIT_SPACE;
                        end
                    end
                end
                ST_WAIT_SPACE: begin
                    if (space_ok) begin
                        s_ready_reg <= 1'b1;
                        state_reg   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (xfer) begin
                        wr_en_reg   <= bank_onehot;
                        wr_addr_reg <= wr_addr_next;
                        wr_data_reg <= s.s_data;
                        if (gen_last) begin
                            s_ready_reg <= 1'b0;
                            state_reg   <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    // Publishing wptr one cycle after the final write keeps the reader off uncommitted data
                    wptr_reg  <= wptr_reg + frame_size_reg[B_BUF_ADDR-1:0];
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef FTM_WR_LAST_CHECK_EN
    logic err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (xfer && (s.s_last != gen_last)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign s.s_ready = s_ready_reg;
    assign wr_en     = wr_en_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign wptr      = wptr_reg;

endmodule

// File: tb/tb_ftm_buffer_writer.sv
// Randomized bench for ftm_buffer_writer: expected bank/address come from the layout formula.
module tb_ftm_buffer_writer;

    localparam int N     = 10;
    localparam int B     = 9;
    localparam int DW    = 64;
    localparam int BS    = 25;
    localparam int DEPTH = 512;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [BS-1:0]   ftm_shape;
    logic            busy, done, err;
    logic [N-1:0]    wr_en;
    logic [B*N-1:0]  wr_addr;
    logic [DW-1:0]   wr_data;
    logic [B-1:0]    rptr, wptr;

    ftm_buffer_writer_if #(.DATA_WIDTH(DW)) s_if();

    ftm_buffer_writer #(
        .N_BUF_X(N), .B_BUF_ADDR(B), .B_SHAPE(BS), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ftm_shape(ftm_shape),
        .busy(busy), .done(done), .s(s_if),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rptr(rptr), .wptr(wptr), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int wp_model = 0;

    int           exp_bank[$];
    int           exp_addr[$];
    int           exp_cyc[$];
    logic [DW-1:0] exp_data[$];
    logic [N-1:0]  got_en[$];
    logic [B*N-1:0] got_addr[$];
    logic [DW-1:0] got_data[$];
    int            got_cyc[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (wr_en != '0) begin
            got_en.push_back(wr_en);
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            got_cyc.push_back(cyc_cnt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [BS-1:0] mk_shape(input int w, input int h, input int c);
        return {7'(c), 9'(h), 9'(w)};
    endfunction

    function automatic int frame_size(input int w, input int h, input int c);
        return c * h * ((w + N - 1) / N);
    endfunction

    task automatic clear_queues();
        exp_bank.delete(); exp_addr.delete(); exp_cyc.delete(); exp_data.delete();
        got_en.delete(); got_addr.delete(); got_data.delete(); got_cyc.delete();
    endtask

    task automatic start_frame(input int w, input int h, input int c);
        @(negedge clk);
        start = 1'b1;
        ftm_shape = mk_shape(w, h, c);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives words in c,y,x order; on each accepted word records its expected bank write.
    task automatic drive_frame(input int w, input int h, input int c, input int gap_pct,
                               input int last_at, input int stop_after, output int n_sent);
        int n, idx, guard, col, x, rem, y, cc;
        logic [DW-1:0] cur;
        n = w * h * c;
        if (stop_after < n) n = stop_after;
        col = c * h;
        idx = 0;
        guard = 0;
        cur = {$urandom, $urandom};
        while (idx < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            s_if.s_valid = (gap_pct == 0) || ($urandom_range(0, 99) >= gap_pct);
            s_if.s_data  = cur;
            s_if.s_last  = (idx == last_at);
            if (s_if.s_valid && s_if.s_ready) begin
                x   = idx / col;
                rem = idx % col;
                y   = rem / c;
                cc  = rem % c;
                exp_bank.push_back(x % N);
                exp_addr.push_back((wp_model + c * (y + h * (x / N)) + cc) % DEPTH);
                exp_data.push_back(cur);
                exp_cyc.push_back(cyc_cnt + 1);
                idx++;
                cur = {$urandom, $urandom};
            end
        end
        @(negedge clk);
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        n_sent = idx;
    endtask

    task automatic wait_done(output int seen);
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ftm_shape = '0; rptr = '0;
        s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, s_if.s_ready, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/s_ready/err=%b required 0000", {busy, done, s_if.s_ready, err});
        end
        checks++;
        if (wr_en !== '0 || wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_write_bus: wr_en=%b wr_addr=%h wr_data=%h required all 0", wr_en, wr_addr, wr_data);
        end
        checks++;
        if (wptr !== '0) begin
            errors++;
            $display("FAIL reset_wptr: wptr=%0d required 0", wptr);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_if.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b s_ready=%b required 0 0", busy, s_if.s_ready);
        end
        wp_model = 0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int n, seen;
        logic [N-1:0] e;
        logic [B*N-1:0] a;
        clear_queues();
        rptr = B'(wp_model);
        start_frame(12, 2, 3);
        drive_frame(12, 2, 3, 0, 71, 1000, n);
        wait_done(seen);
        wp_model = (wp_model + frame_size(12, 2, 3)) % DEPTH;
        checks++;
        if (got_en.size() != exp_bank.size() || n != 72) begin
            errors++;
            $display("FAIL basic_count: writes=%0d sent=%0d required %0d", got_en.size(), n, 72);
        end
        for (int i = 0; i < got_en.size() && i < exp_bank.size(); i++) begin
            e = N'(1) << exp_bank[i];
            a = (B*N)'(exp_addr[i]) << (B * exp_bank[i]);
            checks++;
            if (got_en[i] !== e || got_addr[i] !== a || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL basic_word %0d: en=%b addr=%h data=%h cyc=%0d required en=%b addr=%h data=%h cyc=%0d",
                         i, got_en[i], got_addr[i], got_data[i], got_cyc[i], e, a, exp_data[i], exp_cyc[i]);
            end
        end
        if (got_en.size() > 60) begin
            checks++;
            if (got_en[12] !== 10'b00_0000_0100 || got_addr[12][2*B +: B] !== 9'd0) begin
                errors++;
                $display("FAIL basic_word12: en=%b addr=%0d required bank2 addr0", got_en[12], got_addr[12][2*B +: B]);
            end
            checks++;
            if (got_en[60] !== 10'b00_0000_0001 || got_addr[60][0 +: B] !== 9'd6) begin
                errors++;
                $display("FAIL basic_word60: en=%b addr=%0d required bank0 addr6", got_en[60], got_addr[60][0 +: B]);
            end
        end
        checks++;
        if (seen != 1 || wptr !== 9'd12 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_commit: done_seen=%0d wptr=%0d busy=%b err=%b required 1 12 0 0", seen, wptr, busy, err);
        end
        $display("test_basic done: %0d writes", got_en.size());
    endtask

    task automatic test_gaps();
        int n, seen, bank0, bank0_exp;
        logic [N-1:0] e;
        logic [B*N-1:0] a;
        clear_queues();
        rptr = B'(wp_model);
        start_frame(12, 2, 3);
        drive_frame(12, 2, 3, 50, 71, 1000, n);
        wait_done(seen);
        wp_model = (wp_model + frame_size(12, 2, 3)) % DEPTH;
        bank0 = 0;
        bank0_exp = 0;
        foreach (got_en[i]) if (got_en[i][0]) bank0++;
        foreach (exp_bank[i]) if (exp_bank[i] == 0) bank0_exp++;
        checks++;
        if (got_en.size() != 72 || bank0 != 12 || bank0_exp != 12) begin
            errors++;
            $display("FAIL gaps_count: writes=%0d bank0=%0d required 72 and 12", got_en.size(), bank0);
        end
        for (int i = 0; i < got_en.size() && i < exp_bank.size(); i++) begin
            e = N'(1) << exp_bank[i];
            a = (B*N)'(exp_addr[i]) << (B * exp_bank[i]);
            checks++;
            if (got_en[i] !== e || got_addr[i] !== a || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL gaps_word %0d: en=%b addr=%h data=%h cyc=%0d required en=%b addr=%h data=%h cyc=%0d",
                         i, got_en[i], got_addr[i], got_data[i], got_cyc[i], e, a, exp_data[i], exp_cyc[i]);
            end
        end
        checks++;
        if (seen != 1 || wptr !== B'(wp_model)) begin
            errors++;
            $display("FAIL gaps_commit: done_seen=%0d wptr=%0d required 1 %0d", seen, wptr, wp_model);
        end
        $display("test_gaps done: %0d writes", got_en.size());
    endtask

    task automatic test_wrap();
        int n, seen, fill;
        logic [N-1:0] e;
        logic [B*N-1:0] a;
        // Filler frame (w=1, so one column of depth c*h) moves wptr up to 500
        fill = 500 - wp_model;
        clear_queues();
        rptr = B'(wp_model);
        start_frame(1, fill / 4, 4);
        drive_frame(1, fill / 4, 4, 0, fill - 1, 2000, n);
        wait_done(seen);
        wp_model = (wp_model + frame_size(1, fill / 4, 4)) % DEPTH;
        checks++;
        if (seen != 1 || wptr !== 9'd500 || got_en.size() != fill) begin
            errors++;
            $display("FAIL wrap_fill: done_seen=%0d wptr=%0d writes=%0d required 1 500 %0d", seen, wptr, got_en.size(), fill);
        end
        clear_queues();
        rptr = 9'd5;
        start_frame(12, 2, 3);
        drive_frame(12, 2, 3, 0, 71, 1000, n);
        wait_done(seen);
        wp_model = (wp_model + frame_size(12, 2, 3)) % DEPTH;
        for (int i = 0; i < got_en.size() && i < exp_bank.size(); i++) begin
            e = N'(1) << exp_bank[i];
            a = (B*N)'(exp_addr[i]) << (B * exp_bank[i]);
            checks++;
            if (got_en[i] !== e || got_addr[i] !== a || got_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL wrap_word %0d: en=%b addr=%h data=%h required en=%b addr=%h data=%h",
                         i, got_en[i], got_addr[i], got_data[i], e, a, exp_data[i]);
            end
        end
        checks++;
        if (got_en.size() != 72) begin
            errors++;
            $display("FAIL wrap_count: writes=%0d required 72", got_en.size());
        end else if (got_addr[60][0 +: B] !== 9'd506 || got_addr[65][0 +: B] !== 9'd511) begin
            errors++;
            $display("FAIL wrap_x10_addr: word60=%0d word65=%0d required 506 511", got_addr[60][0 +: B], got_addr[65][0 +: B]);
        end
        checks++;
        if (seen != 1 || wptr !== 9'd0) begin
            errors++;
            $display("FAIL wrap_commit: done_seen=%0d wptr=%0d required 1 0", seen, wptr);
        end
        $display("test_wrap done: wptr=%0d", wptr);
    endtask

    task automatic test_space();
        int n, seen, ready_seen;
        logic [N-1:0] e;
        logic [B*N-1:0] a;
        clear_queues();
        rptr = B'((wp_model + 17) % DEPTH);
        start_frame(20, 2, 5);
        ready_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (s_if.s_ready !== 1'b0) ready_seen++;
        end
        checks++;
        if (ready_seen != 0 || busy !== 1'b1 || got_en.size() != 0) begin
            errors++;
            $display("FAIL space_hold: ready_cycles=%0d busy=%b writes=%0d required 0 1 0", ready_seen, busy, got_en.size());
        end
        rptr = B'((wp_model + 21) % DEPTH);
        @(negedge clk);
        checks++;
        if (s_if.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL space_release: s_ready=%b required 1", s_if.s_ready);
        end
        drive_frame(20, 2, 5, 0, 199, 1000, n);
        wait_done(seen);
        wp_model = (wp_model + frame_size(20, 2, 5)) % DEPTH;
        for (int i = 0; i < got_en.size() && i < exp_bank.size(); i++) begin
            e = N'(1) << exp_bank[i];
            a = (B*N)'(exp_addr[i]) << (B * exp_bank[i]);
            checks++;
            if (got_en[i] !== e || got_addr[i] !== a || got_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL space_word %0d: en=%b addr=%h required en=%b addr=%h", i, got_en[i], got_addr[i], e, a);
            end
        end
        checks++;
        if (seen != 1 || wptr !== B'(wp_model) || got_en.size() != 200) begin
            errors++;
            $display("FAIL space_commit: done_seen=%0d wptr=%0d writes=%0d required 1 %0d 200", seen, wptr, got_en.size(), wp_model);
        end
        $display("test_space done: wptr=%0d", wptr);
    endtask

    task automatic test_zero_shape();
        int extra_done;
        clear_queues();
        start_frame(12, 0, 3);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b required 1 0", done, busy);
        end
        extra_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) extra_done++;
        end
        checks++;
        if (extra_done != 0 || got_en.size() != 0 || wptr !== B'(wp_model)) begin
            errors++;
            $display("FAIL zero_quiet: bad_cycles=%0d writes=%0d wptr=%0d required 0 0 %0d", extra_done, got_en.size(), wptr, wp_model);
        end
        $display("test_zero_shape done");
    endtask

    task automatic test_start_ignored();
        int n, seen, writes_after;
        logic [N-1:0] e;
        logic [B*N-1:0] a;
        clear_queues();
        rptr = B'(wp_model);
        start_frame(12, 2, 3);
        fork
            drive_frame(12, 2, 3, 0, 71, 1000, n);
            begin
                repeat (20) @(negedge clk);
                start = 1'b1;
                ftm_shape = mk_shape(3, 1, 1);
                @(negedge clk);
                start = 1'b0;
            end
        join
        wait_done(seen);
        wp_model = (wp_model + frame_size(12, 2, 3)) % DEPTH;
        for (int i = 0; i < got_en.size() && i < exp_bank.size(); i++) begin
            e = N'(1) << exp_bank[i];
            a = (B*N)'(exp_addr[i]) << (B * exp_bank[i]);
            checks++;
            if (got_en[i] !== e || got_addr[i] !== a || got_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL ignore_word %0d: en=%b addr=%h required en=%b addr=%h", i, got_en[i], got_addr[i], e, a);
            end
        end
        writes_after = got_en.size();
        repeat (10) @(negedge clk);
        checks++;
        if (seen != 1 || busy !== 1'b0 || got_en.size() != 72 || writes_after != 72 || wptr !== B'(wp_model)) begin
            errors++;
            $display("FAIL ignore_idle: done_seen=%0d busy=%b writes=%0d wptr=%0d required 1 0 72 %0d",
                     seen, busy, got_en.size(), wptr, wp_model);
        end
        $display("test_start_ignored done");
    endtask

    task automatic test_last_check();
        int n, seen;
        logic exp_err;
`ifdef FTM_WR_LAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        clear_queues();
        rptr = B'(wp_model);
        start_frame(12, 2, 3);
        drive_frame(12, 2, 3, 0, 5, 1000, n);
        wait_done(seen);
        wp_model = (wp_model + frame_size(12, 2, 3)) % DEPTH;
        checks++;
        if (err !== exp_err || got_en.size() != 72 || seen != 1) begin
            errors++;
            $display("FAIL last_check: err=%b writes=%0d done_seen=%0d required %b 72 1", err, got_en.size(), seen, exp_err);
        end
        $display("test_last_check done: err=%b", err);
    endtask

    task automatic test_midreset();
        int n, seen;
        logic [N-1:0] e;
        logic [B*N-1:0] a;
        clear_queues();
        rptr = B'(wp_model);
        start_frame(12, 2, 3);
        drive_frame(12, 2, 3, 0, 71, 20, n);
        checks++;
        if (s_if.s_ready !== 1'b1 || busy !== 1'b1 || n != 20) begin
            errors++;
            $display("FAIL midreset_pre: s_ready=%b busy=%b sent=%0d required 1 1 20", s_if.s_ready, busy, n);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, s_if.s_ready, err} !== 4'b0000 || wr_en !== '0 || wr_addr !== '0 || wr_data !== '0 || wptr !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: flags=%b wr_en=%b wr_addr=%h wr_data=%h wptr=%0d required all 0",
                     {busy, done, s_if.s_ready, err}, wr_en, wr_addr, wr_data, wptr);
        end
        rst = 1'b0;
        wp_model = 0;
        rptr = '0;
        clear_queues();
        start_frame(3, 1, 1);
        drive_frame(3, 1, 1, 0, 2, 100, n);
        wait_done(seen);
        wp_model = (wp_model + frame_size(3, 1, 1)) % DEPTH;
        for (int i = 0; i < got_en.size() && i < exp_bank.size(); i++) begin
            e = N'(1) << exp_bank[i];
            a = (B*N)'(exp_addr[i]) << (B * exp_bank[i]);
            checks++;
            if (got_en[i] !== e || got_addr[i] !== a || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL post_reset_word %0d: en=%b addr=%h required en=%b addr=%h", i, got_en[i], got_addr[i], e, a);
            end
        end
        checks++;
        if (seen != 1 || wptr !== 9'd1 || got_en.size() != 3) begin
            errors++;
            $display("FAIL post_reset_commit: done_seen=%0d wptr=%0d writes=%0d required 1 1 3", seen, wptr, got_en.size());
        end
        $display("test_midreset done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_wrap();
        test_space();
        test_zero_shape();
        test_start_ignored();
        test_last_check();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
